// File: rtl/ifetch_pkg.sv
// Shared widths, reset address and queue entry type for the instruction fetch unit.
package ifetch_pkg;
  localparam int                  ADDR_W   = 8;
  localparam int                  INSTR_W  = 16;
  localparam logic [ADDR_W-1:0]   RESET_PC = 8'h00;
  localparam logic [INSTR_W-1:0]  NOP_WORD = 16'h0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: ROM read port, decode valid/ready handshake and execute redirect.
// master = fetch unit, slave = environment (ROM + decode + execute).
interface instruction_fetch_unit_if;
  import ifetch_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halted;

  modport master (
    output imem_addr, instr, instr_pc, instr_valid, halted,
    input  imem_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_addr, instr, instr_pc, instr_valid, halted,
    output imem_data, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of fetch_entry_t.
// flush wins over push/pop; push on a full queue is accepted only alongside a pop.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // pointer and occupancy bookkeeping; flush empties the queue outright
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage needs no reset: the head is only observed when count is non-zero
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the fetch PC, reads the ROM combinationally and
// buffers {pc, instr} in a small prefetch queue feeding decode.
// Optional macro IFETCH_BOUNDS_EN: stop fetching after the word at END_ADDR.
module instruction_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] END_ADDR = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_unit_if.master  bus
);
  logic [ADDR_W-1:0]      fpc;
  logic                   halted_q;
  logic                   push, pop;
  fetch_entry_t           q_din, q_head;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full, q_empty;

  // a pop in a redirect cycle is harmless: flush has priority inside the queue
  assign pop   = ~q_empty & bus.instr_ready;
  assign push  = ~bus.redirect & ~halted_q & (~q_full | pop);
  assign q_din = '{pc: fpc, instr: bus.imem_data};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.imem_addr   = fpc;
  assign bus.instr_valid = ~q_empty;
  assign bus.instr       = q_empty ? NOP_WORD : q_head.instr;
  assign bus.instr_pc    = q_empty ? '0       : q_head.pc;
  assign bus.halted      = halted_q;

`ifdef IFETCH_BOUNDS_EN
  // fetch PC: redirect reloads, each push advances, but never past END_ADDR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          fpc <= RESET_PC;
    else if (bus.redirect)               fpc <= bus.redirect_pc;
    else if (push && fpc != END_ADDR)    fpc <= fpc + 1'b1;
  end

  // halt once the END_ADDR word is queued; only a redirect restarts fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          halted_q <= 1'b0;
    else if (bus.redirect)               halted_q <= 1'b0;
    else if (push && fpc == END_ADDR)    halted_q <= 1'b1;
  end

  logic unused_sig;
  assign unused_sig = ^q_count;
`else
  // fetch PC: redirect reloads, each push advances with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             fpc <= RESET_PC;
    else if (bus.redirect)  fpc <= bus.redirect_pc;
    else if (push)          fpc <= fpc + 1'b1;
  end

  assign halted_q = 1'b0;

  // END_ADDR has no meaning without the fetch bound
  logic unused_sig;
  assign unused_sig = ^{END_ADDR, q_count};
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
// With IFETCH_BOUNDS_EN defined the DUT is built with END_ADDR = 8'h11.
module tb_instruction_fetch_unit;
  import ifetch_pkg::*;

`ifdef IFETCH_BOUNDS_EN
  localparam logic [7:0] EA = 8'h11;
`else
  localparam logic [7:0] EA = 8'hFF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(.DEPTH(2), .END_ADDR(EA)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   rom = 16'h0000;
      8'h01:   rom = 16'h4806;
      8'h02:   rom = 16'h4A04;
      8'h03:   rom = 16'h2203;
      8'h10:   rom = 16'h8850;
      8'h11:   rom = 16'h9A11;
      8'h12:   rom = 16'hB012;
      8'hFE:   rom = 16'h7EFE;
      8'hFF:   rom = 16'h6FFF;
      default: rom = 16'hDEAD;
    endcase
  endfunction

  assign bus.imem_data = rom(bus.imem_addr);

  // settle point one unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [24:0] hd();
    return {bus.instr_valid, bus.instr_pc, bus.instr};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    #3;
    checks++;
    if ({hd(), bus.imem_addr, bus.halted} !== {1'b0, 8'h00, 16'h0000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", {hd(), bus.imem_addr, bus.halted}, 34'h0);
    end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [24:0] exp [3];
    exp[0] = {1'b1, 8'h00, 16'h0000};
    exp[1] = {1'b1, 8'h01, 16'h4806};
    exp[2] = {1'b1, 8'h02, 16'h4A04};
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (hd() !== exp[i]) begin
        errors++;
        $display("FAIL stream_%0d got %h exp %h", i, hd(), exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [24:0] exp [3];
    apply_reset();
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (hd() !== {1'b1, 8'h00, 16'h0000}) begin
        errors++;
        $display("FAIL stall_head_%0d got %h exp %h", i, hd(), {1'b1, 8'h00, 16'h0000});
      end
      checks++;
      if (bus.imem_addr !== ((i == 0) ? 8'h01 : 8'h02)) begin
        errors++;
        $display("FAIL stall_addr_%0d got %h exp %h", i, bus.imem_addr, (i == 0) ? 8'h01 : 8'h02);
      end
    end
    bus.instr_ready = 1'b1;
    exp[0] = {1'b1, 8'h01, 16'h4806};
    exp[1] = {1'b1, 8'h02, 16'h4A04};
    exp[2] = {1'b1, 8'h03, 16'h2203};
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (hd() !== exp[i]) begin
        errors++;
        $display("FAIL stall_release_%0d got %h exp %h", i, hd(), exp[i]);
      end
    end
  endtask

  task automatic test_redirect();
    logic [24:0] exp [3];
    // fill the queue, then redirect in the same cycle decode pops
    bus.instr_ready = 1'b0;
    cyc();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h10;
    cyc();
    bus.redirect = 1'b0;
    checks++;
    if ({hd(), bus.imem_addr} !== {1'b0, 8'h00, 16'h0000, 8'h10}) begin
      errors++;
      $display("FAIL redirect_flush got %h exp %h", {hd(), bus.imem_addr}, {1'b0, 8'h00, 16'h0000, 8'h10});
    end
    exp[0] = {1'b1, 8'h10, 16'h8850};
    exp[1] = {1'b1, 8'h11, 16'h9A11};
    exp[2] = {1'b1, 8'h12, 16'hB012};
`ifdef IFETCH_BOUNDS_EN
    exp[2] = {1'b0, 8'h00, 16'h0000};
`endif
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (hd() !== exp[i]) begin
        errors++;
        $display("FAIL redirect_seq_%0d got %h exp %h", i, hd(), exp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [24:0] exp [4];
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'hFE;
    cyc();
    bus.redirect = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.halted} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_flush got %b exp %b", {bus.instr_valid, bus.halted}, 2'b00);
    end
    exp[0] = {1'b1, 8'hFE, 16'h7EFE};
    exp[1] = {1'b1, 8'hFF, 16'h6FFF};
    exp[2] = {1'b1, 8'h00, 16'h0000};
    exp[3] = {1'b1, 8'h01, 16'h4806};
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (hd() !== exp[i]) begin
        errors++;
        $display("FAIL wrap_seq_%0d got %h exp %h", i, hd(), exp[i]);
      end
    end
  endtask

`ifdef IFETCH_BOUNDS_EN
  task automatic test_bounds();
    logic [25:0] exp [4];
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h10;
    cyc();
    bus.redirect = 1'b0;
    // {halted, valid, pc, instr}
    exp[0] = {1'b0, 1'b0, 8'h00, 16'h0000};
    exp[1] = {1'b0, 1'b1, 8'h10, 16'h8850};
    exp[2] = {1'b1, 1'b1, 8'h11, 16'h9A11};
    exp[3] = {1'b1, 1'b0, 8'h00, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      checks++;
      if ({bus.halted, hd()} !== exp[i]) begin
        errors++;
        $display("FAIL bounds_%0d got %h exp %h", i, {bus.halted, hd()}, exp[i]);
      end
    end
    cyc();
    checks++;
    if ({bus.halted, bus.instr_valid, bus.imem_addr} !== {1'b1, 1'b0, 8'h11}) begin
      errors++;
      $display("FAIL bounds_hold got %h exp %h", {bus.halted, bus.instr_valid, bus.imem_addr}, {1'b1, 1'b0, 8'h11});
    end
  endtask
`endif

  task automatic test_async_reset();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h10;
    cyc();
    bus.redirect = 1'b0;
    cyc();
    #3;
    // drop reset between edges while a redirect is being presented
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hd(), bus.imem_addr, bus.halted} !== {1'b0, 8'h00, 16'h0000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", {hd(), bus.imem_addr, bus.halted}, 34'h0);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.imem_addr} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", {bus.instr_valid, bus.imem_addr}, 9'h0);
    end
    bus.redirect = 1'b0;
    rst_n = 1'b1;
    cyc();
    checks++;
    if (hd() !== {1'b1, 8'h00, 16'h0000}) begin
      errors++;
      $display("FAIL post_reset got %h exp %h", hd(), {1'b1, 8'h00, 16'h0000});
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
`ifdef IFETCH_BOUNDS_EN
    test_bounds();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // guard against a stuck run
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Reader side of the instruction ROM: owns the fetch program counter, drives the ROM address, captures each 16-bit instruction word with its address into a small prefetch queue, and presents the words to decode through a valid/ready handshake. Sits between the instruction memory and the decode stage of the 8-bit MIPS core; takes branch/jump redirects from execute.

## Interface
- ADDR_W, 8, instruction address width (ROM depth 2^ADDR_W words)
- INSTR_W, 16, instruction word width
- RESET_PC, 8'h00, fetch address after reset
- DEPTH, 2, prefetch queue entries (power of two, ≥2)
- END_ADDR, 8'hFF, last fetchable address (used only with IFETCH_BOUNDS_EN)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  ROM address; combinational copy of fetch PC
- imem_data  in  INSTR_W  ROM word; combinationally valid in the same cycle as imem_addr
- instr  out  INSTR_W  queue-head instruction
- instr_pc  out  ADDR_W  address of instr
- instr_valid  out  1  queue head holds a valid word
- instr_ready  in  1  decode accepts head this cycle
- redirect  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  ADDR_W  new fetch address, sampled when redirect=1
- halted  out  1  fetch stopped at END_ADDR (tied 0 without IFETCH_BOUNDS_EN)

## Operation
- State: fetch PC fpc, queue of {pc, instr} entries, count.
- pop = instr_valid & instr_ready. push = !redirect & !halted & (count < DEPTH | pop).
- On push: enqueue {fpc, imem_data}; fpc ← fpc + 1 modulo 2^ADDR_W (0xFF → 0x00).
- Push and pop in same cycle on full queue: both happen, count unchanged.
- redirect=1: queue flushed (count ← 0), fpc ← redirect_pc, no push, any pop that cycle discarded. Redirect overrides everything including halted.
- instr/instr_pc hold head entry; when empty, instr = 16'h0000 (NOP), instr_pc = 0, instr_valid = 0.
- Head must stay stable while instr_valid=1 and instr_ready=0.
- Reset (asynchronous, any time, including mid-redirect): fpc ← RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, halted=0, imem_addr=RESET_PC.

## Timing
- Queue is registered; word pushed at edge N appears on instr/instr_valid after edge N (1-cycle fetch latency).
- First edge after rst_n release pushes RESET_PC; instr_valid high in the following cycle.
- Redirect sampled at edge k: instr_valid low in cycle k+1; word at redirect_pc valid in cycle k+2.
- Sustained throughput: one instruction per cycle when instr_ready held high.
- Decode stall: queue fills in DEPTH cycles, then imem_addr holds constant.

## Configuration
- IFETCH_BOUNDS_EN defined: after pushing the word at END_ADDR, halted ← 1 on the same edge; no further pushes; queue still drains; halted cleared only by redirect or reset. fpc does not wrap past END_ADDR.
- Not defined: no bound; fpc wraps modulo 2^ADDR_W; halted constant 0; END_ADDR ignored.

## Structure
- Package ifetch_pkg: ADDR_W, INSTR_W, RESET_PC, NOP_WORD = 16'h0000, typedef fetch_entry_t {pc, instr}.
- One sub-module: fetch_queue — DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, full, empty; flush has priority over push/pop.
- Top contains fpc, push/pop/redirect logic and halt flag.

## Test plan
- Reset, ROM model 0x00:0000, 0x01:4806, 0x02:4A04, instr_ready=1 -> consecutive cycles show (pc,instr) = (00,0000), (01,4806), (02,4A04), instr_valid held high.
- instr_ready=0 for 5 cycles after first valid -> head stays (00,0000), imem_addr stops at 0x02 after queue holds 2 entries; release -> (01,4806) next, no word lost or duplicated.
- redirect=1, redirect_pc=0x10 while queue full and pop asserted -> next cycle instr_valid=0; following cycle (10, ROM[0x10]=8850); old entries never appear.
- Run from redirect_pc=0xFE without macro -> sequence pc FE, FF, 00, 01; with IFETCH_BOUNDS_EN and END_ADDR=0x11 from 0x10 -> pcs 10, 11 delivered, halted=1, instr_valid falls after drain.
- rst_n pulsed low mid-stream, asynchronously between edges -> outputs immediately 0/invalid, imem_addr=RESET_PC; after release first word is (00,0000).
